// File: rtl/bp_common_pkg.sv
// Shared coherence-network types: arbiter state and select-width helper.
package bp_common_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } bp_arb_state_e;

   function automatic int bp_sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bp_coh_chan_mux_if.sv
// LCE-side input channels and granted output beat of the coherence channel mux.
interface bp_coh_chan_mux_if #(
   parameter int num_in_p = 2,
   parameter int width_p  = 64
) ();
   import bp_common_pkg::*;

   localparam int src_w_lp = bp_sel_width(num_in_p);

   logic [num_in_p-1:0][width_p-1:0] data_i;
   logic [num_in_p-1:0]              v_i;
   logic [num_in_p-1:0]              last_i;
   logic [num_in_p-1:0]              ready_o;
   logic [width_p-1:0]               data_o;
   logic                             v_o;
   logic                             last_o;
   logic [src_w_lp-1:0]              src_o;
   logic                             yumi_i;

   modport master (
      output data_i, v_i, last_i, yumi_i,
      input  ready_o, data_o, v_o, last_o, src_o
   );

   modport slave (
      input  data_i, v_i, last_i, yumi_i,
      output ready_o, data_o, v_o, last_o, src_o
   );

endinterface

// File: rtl/bp_coh_chan_rr_arb.sv
// Round-robin grant with per-message lock; last_grant moves on each final beat.
module bp_coh_chan_rr_arb
   import bp_common_pkg::*;
#(
   parameter int num_in_p = 2,
   localparam int sel_w_lp = bp_sel_width(num_in_p)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [num_in_p-1:0] i_req,
   input  logic                i_yumi,
   input  logic                i_last,
   output logic                o_v,
   output logic [sel_w_lp-1:0] o_sel
);

   bp_arb_state_e       r_state;
   logic [sel_w_lp-1:0] r_lock_id;
   logic [sel_w_lp-1:0] r_last_grant;
   logic [sel_w_lp-1:0] w_cand;
   logic [sel_w_lp-1:0] w_sel;
   logic                w_found;

   always_comb begin
      w_sel   = '0;
      w_found = 1'b0;
      w_cand  = '0;
      if (r_state == LOCKED) begin
         w_sel   = r_lock_id;
         w_found = i_req[r_lock_id];
      end else begin
         for (int i = 1; i <= num_in_p; i++) begin
            w_cand = sel_w_lp'((int'(r_last_grant) + i) % num_in_p);
            if (!w_found && i_req[w_cand]) begin
               w_found = 1'b1;
               w_sel   = w_cand;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_lock_id    <= '0;
         r_last_grant <= sel_w_lp'(num_in_p - 1);
      end else if (i_yumi && w_found) begin
         if (i_last) begin
            r_state      <= IDLE;
            r_last_grant <= w_sel;
         end else begin
            r_state   <= LOCKED;
            r_lock_id <= w_sel;
         end
      end
   end

   assign o_v   = w_found;
   assign o_sel = w_sel;

endmodule

// File: rtl/bp_coh_chan_mux.sv
// Per-channel FIFOs feeding a locked round-robin mux; outputs come only from FIFO heads.
// Optional stall counter output enabled by BP_COH_CHAN_MUX_STALL_CNT_EN.
module bp_coh_chan_mux
   import bp_common_pkg::*;
#(
   parameter int num_in_p   = 2,
   parameter int width_p    = 64,
   parameter int fifo_els_p = 2
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
`ifdef BP_COH_CHAN_MUX_STALL_CNT_EN
   output logic [31:0]      stall_cnt_o,
`endif
   bp_coh_chan_mux_if.slave ch
);

   localparam int sel_w_lp = bp_sel_width(num_in_p);
   localparam int ptr_w_lp = $clog2(fifo_els_p);

   logic                r_en;
   logic [num_in_p-1:0] w_full;
   logic [num_in_p-1:0] w_empty;
   logic [num_in_p-1:0] w_enq;
   logic [num_in_p-1:0] w_deq;
   logic [num_in_p-1:0] w_head_last;
   logic [width_p-1:0]  w_head_data [num_in_p];
   logic                w_v;
   logic [sel_w_lp-1:0] w_sel;

   // ready stays low until the first edge after reset release
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) r_en <= 1'b0;
      else            r_en <= 1'b1;
   end

   for (genvar k = 0; k < num_in_p; k++) begin : g_fifo
      logic [width_p-1:0] r_mem  [fifo_els_p];
      logic               r_lmem [fifo_els_p];
      logic [ptr_w_lp:0]  r_wptr;
      logic [ptr_w_lp:0]  r_rptr;

      assign w_empty[k] = (r_wptr == r_rptr);
      assign w_full[k]  = (r_wptr[ptr_w_lp] != r_rptr[ptr_w_lp])
                       && (r_wptr[ptr_w_lp-1:0] == r_rptr[ptr_w_lp-1:0]);
      assign w_enq[k]   = ch.v_i[k] & ch.ready_o[k];
      assign w_deq[k]   = ch.yumi_i & w_v & (w_sel == sel_w_lp'(k));

      assign w_head_data[k] = r_mem[r_rptr[ptr_w_lp-1:0]];
      assign w_head_last[k] = r_lmem[r_rptr[ptr_w_lp-1:0]];

      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_enq[k]) r_wptr <= r_wptr + 1'b1;
            if (w_deq[k]) r_rptr <= r_rptr + 1'b1;
         end
      end

      always_ff @(posedge clk_i) begin
         if (w_enq[k]) begin
            r_mem[r_wptr[ptr_w_lp-1:0]]  <= ch.data_i[k];
            r_lmem[r_wptr[ptr_w_lp-1:0]] <= ch.last_i[k];
         end
      end
   end

   bp_coh_chan_rr_arb #(
      .num_in_p (num_in_p)
   ) u_arb (
      .i_clk   (clk_i),
      .i_rst_n (reset_n_i),
      .i_req   (~w_empty),
      .i_yumi  (ch.yumi_i),
      .i_last  (w_head_last[w_sel]),
      .o_v     (w_v),
      .o_sel   (w_sel)
   );

   assign ch.ready_o = {num_in_p{r_en}} & ~w_full;
   assign ch.v_o     = w_v;
   assign ch.src_o   = w_sel;
   assign ch.data_o  = w_v ? w_head_data[w_sel] : '0;
   assign ch.last_o  = w_v & w_head_last[w_sel];

`ifdef BP_COH_CHAN_MUX_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
         r_stall_cnt <= '0;
      else if (w_v && !ch.yumi_i && (r_stall_cnt != '1))
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign stall_cnt_o = r_stall_cnt;
`endif

   assert property (@(posedge clk_i) disable iff (!reset_n_i)
      ch.yumi_i |-> ch.v_o)
   else $error("bp_coh_chan_mux: yumi_i asserted while v_o low");

endmodule

// File: tb/tb_bp_coh_chan_mux.sv
// Directed scoreboard bench for bp_coh_chan_mux (2 channels, 64-bit, depth 2).
module tb_bp_coh_chan_mux;

   typedef struct {
      logic [0:0]  src;
      logic [63:0] data;
      logic        last;
   } beat_t;

   logic  clk;
   logic  rst_n;
   int    errors;
   int    checks;
   beat_t sb[$];
`ifdef BP_COH_CHAN_MUX_STALL_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] s0;
`endif

   bp_coh_chan_mux_if #(.num_in_p(2), .width_p(64)) bus ();

   bp_coh_chan_mux #(
      .num_in_p   (2),
      .width_p    (64),
      .fifo_els_p (2)
   ) dut (
      .clk_i       (clk),
      .reset_n_i   (rst_n),
`ifdef BP_COH_CHAN_MUX_STALL_CNT_EN
      .stall_cnt_o (stall_cnt),
`endif
      .ch          (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int src, input logic [63:0] d, input logic l);
      beat_t e;
      e.src  = 1'(src);
      e.data = d;
      e.last = l;
      sb.push_back(e);
   endtask

   task automatic send(input int c, input logic [63:0] d, input logic l);
      bus.v_i[c]    = 1'b1;
      bus.data_i[c] = d;
      bus.last_i[c] = l;
      @(negedge clk);
      bus.v_i[c]    = 1'b0;
   endtask

   task automatic take(input string tag);
      beat_t e;
      int    n;
      n = 0;
      while (bus.v_o !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus.v_o !== 1'b1) begin
         chk({tag, "_timeout"}, 64'(bus.v_o), 64'd1);
      end else if (sb.size() == 0) begin
         chk({tag, "_sb_underflow"}, 64'(sb.size()), 64'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_src"}, 64'(bus.src_o), 64'(e.src));
         chk({tag, "_data"}, bus.data_o, e.data);
         chk({tag, "_last"}, 64'(bus.last_o), 64'(e.last));
         bus.yumi_i = 1'b1;
         @(negedge clk);
         bus.yumi_i = 1'b0;
      end
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      clk         = 1'b0;
      rst_n       = 1'b0;
      errors      = 0;
      checks      = 0;
      bus.v_i     = '0;
      bus.data_i  = '0;
      bus.last_i  = '0;
      bus.yumi_i  = 1'b0;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(bus.ready_o), 64'd0);
      chk("rst_v", 64'(bus.v_o), 64'd0);
      chk("rst_last", 64'(bus.last_o), 64'd0);
      chk("rst_src", 64'(bus.src_o), 64'd0);
      chk("rst_data", bus.data_o, 64'd0);
`ifdef BP_COH_CHAN_MUX_STALL_CNT_EN
      chk("rst_stall", 64'(stall_cnt), 64'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_first_edge", 64'(bus.ready_o), 64'd3);

      // single beat, one-cycle latency, no bypass
      push(0, 64'hA5, 1'b1);
      chk("no_bypass", 64'(bus.v_o), 64'd0);
      send(0, 64'hA5, 1'b1);
      chk("lat1_v", 64'(bus.v_o), 64'd1);
      take("single");

      // fairness: both channels loaded, expect 0,1,0,1
      reset_dut();
      send(0, 64'h11, 1'b1);
      send(0, 64'h12, 1'b1);
      send(1, 64'h21, 1'b1);
      send(1, 64'h22, 1'b1);
      push(0, 64'h11, 1'b1);
      push(1, 64'h21, 1'b1);
      push(0, 64'h12, 1'b1);
      push(1, 64'h22, 1'b1);
      repeat (4) take("fair");

      // lock: 3-beat message on ch1 holds off a waiting ch0 beat
      push(1, 64'h41, 1'b0);
      push(1, 64'h42, 1'b0);
      push(1, 64'h43, 1'b1);
      push(0, 64'h31, 1'b1);
      send(1, 64'h41, 1'b0);
      take("lock_b1");
      send(0, 64'h31, 1'b1);
      send(1, 64'h42, 1'b0);
      take("lock_b2");
      chk("lock_hold_v", 64'(bus.v_o), 64'd0);
      chk("lock_hold_src", 64'(bus.src_o), 64'd1);
      send(1, 64'h43, 1'b1);
      take("lock_b3");
      take("lock_after");

      // backpressure on ch0 with depth 2
      bus.v_i[0]    = 1'b1;
      bus.last_i[0] = 1'b1;
      bus.data_i[0] = 64'h51;
      chk("bp_rdy0", 64'(bus.ready_o[0]), 64'd1);
      @(negedge clk);
      bus.data_i[0] = 64'h52;
      chk("bp_rdy1", 64'(bus.ready_o[0]), 64'd1);
      @(negedge clk);
      bus.data_i[0] = 64'h53;
      chk("bp_full", 64'(bus.ready_o[0]), 64'd0);
`ifdef BP_COH_CHAN_MUX_STALL_CNT_EN
      s0 = stall_cnt;
`endif
      @(negedge clk);
      chk("bp_full_hold", 64'(bus.ready_o[0]), 64'd0);
`ifdef BP_COH_CHAN_MUX_STALL_CNT_EN
      chk("bp_stall_inc", 64'(stall_cnt), 64'(s0 + 32'd1));
`endif
      bus.v_i[0] = 1'b0;
      push(0, 64'h51, 1'b1);
      push(0, 64'h52, 1'b1);
      take("bp_b1");
      chk("bp_rdy_again", 64'(bus.ready_o[0]), 64'd1);
      push(0, 64'h53, 1'b1);
      send(0, 64'h53, 1'b1);
      take("bp_b2");
      take("bp_b3");

      // reset in the middle of a ch1 message
      push(1, 64'h61, 1'b0);
      send(1, 64'h61, 1'b0);
      take("mid_b1");
      send(1, 64'h62, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rstmid_v", 64'(bus.v_o), 64'd0);
      chk("rstmid_ready", 64'(bus.ready_o), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push(0, 64'h71, 1'b1);
      send(0, 64'h71, 1'b1);
      chk("post_rst_v", 64'(bus.v_o), 64'd1);
      take("post_rst");

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
